// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: pipeline hazard inputs plus the stall/flush
// controls and status returned to the datapath.
//   master : datapath side, drives the hazard inputs and samples the controls
//   slave  : hazard controller side
interface pipeline_hazard_controller_if #(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned CNT_W      = 16
);
    logic                  redirect_i;
    logic [REG_ADDR_W-1:0] rd_ex_i;
    logic                  mem_read_ex_i;
    logic [REG_ADDR_W-1:0] rs1_id_i;
    logic [REG_ADDR_W-1:0] rs2_id_i;
    logic                  uses_rs2_id_i;
    logic                  mem_access_mem_i;
    logic                  mem_ready_i;

    logic                  pc_enable_o;
    logic                  ifid_enable_o;
    logic                  ifid_clear_o;
    logic                  idex_enable_o;
    logic                  idex_clear_o;
    logic                  exmem_enable_o;
    logic                  memwb_clear_o;
    logic [CNT_W-1:0]      stall_count_o;
    logic                  timeout_o;
    logic [1:0]            state_o;

    modport master (
        output redirect_i, rd_ex_i, mem_read_ex_i, rs1_id_i, rs2_id_i,
               uses_rs2_id_i, mem_access_mem_i, mem_ready_i,
        input  pc_enable_o, ifid_enable_o, ifid_clear_o, idex_enable_o,
               idex_clear_o, exmem_enable_o, memwb_clear_o, stall_count_o,
               timeout_o, state_o
    );

    modport slave (
        input  redirect_i, rd_ex_i, mem_read_ex_i, rs1_id_i, rs2_id_i,
               uses_rs2_id_i, mem_access_mem_i, mem_ready_i,
        output pc_enable_o, ifid_enable_o, ifid_clear_o, idex_enable_o,
               idex_clear_o, exmem_enable_o, memwb_clear_o, stall_count_o,
               timeout_o, state_o
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous reset, active high
//   hz     - slave side of the hazard bundle: redirect, load-use operands and
//            MEM handshake in; per-register enable/clear controls, saturating
//            stall count, sticky timeout flag and state (00 RUN/01 WAIT/10 HALT) out.
// Controls are Mealy: decoded from the registered state and current inputs.
module pipeline_hazard_controller #(
    parameter int unsigned REG_ADDR_W  = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input logic                          clk_i,
    input logic                          rst_i,
    pipeline_hazard_controller_if.slave  hz
);

    localparam int unsigned WAIT_W = 8;
    // A WAIT cycle that is still not ready with this many waits behind it is the last allowed.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    stall_cnt_q;

    logic pc_enable_c, ifid_enable_c, ifid_clear_c, idex_enable_c;
    logic idex_clear_c, exmem_enable_c, memwb_clear_c;
    logic mem_wait_c, load_use_c;

    // Hazard detection; x0 is hard-wired so it never creates a dependency.
    assign mem_wait_c = hz.mem_access_mem_i && !hz.mem_ready_i;
    assign load_use_c = hz.mem_read_ex_i && (hz.rd_ex_i != '0) &&
                        ((hz.rd_ex_i == hz.rs1_id_i) ||
                         (hz.uses_rs2_id_i && (hz.rd_ex_i == hz.rs2_id_i)));

    // State, wait counter and sticky timeout registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state and control decode: memory wait > redirect > load-use.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        timeout_d      = timeout_q;
        pc_enable_c    = 1'b1;
        ifid_enable_c  = 1'b1;
        ifid_clear_c   = 1'b0;
        idex_enable_c  = 1'b1;
        idex_clear_c   = 1'b0;
        exmem_enable_c = 1'b1;
        memwb_clear_c  = 1'b0;

        case (state_q)
            ST_RUN, ST_WAIT: begin
                if (mem_wait_c) begin
                    pc_enable_c    = 1'b0;
                    ifid_enable_c  = 1'b0;
                    idex_enable_c  = 1'b0;
                    exmem_enable_c = 1'b0;
                    memwb_clear_c  = 1'b1;
                    wait_cnt_d     = wait_cnt_q + WAIT_W'(1);
                    state_d        = ST_WAIT;
                    if (state_q == ST_WAIT && wait_cnt_q >= WAIT_LAST) begin
                        state_d   = ST_HALT;
                        timeout_d = 1'b1;
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    if (hz.redirect_i) begin
                        // Squashed ID instruction makes any load-use irrelevant.
                        ifid_clear_c = 1'b1;
                        idex_clear_c = 1'b1;
                    end else if (load_use_c) begin
                        pc_enable_c   = 1'b0;
                        ifid_enable_c = 1'b0;
                        idex_clear_c  = 1'b1;
                    end
                end
            end
            default: begin
                // HALT (and any illegal code): freeze everything, bubble WB.
                state_d        = ST_HALT;
                pc_enable_c    = 1'b0;
                ifid_enable_c  = 1'b0;
                idex_enable_c  = 1'b0;
                exmem_enable_c = 1'b0;
                memwb_clear_c  = 1'b1;
            end
        endcase
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (!pc_enable_c && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign hz.pc_enable_o    = pc_enable_c;
    assign hz.ifid_enable_o  = ifid_enable_c;
    assign hz.ifid_clear_o   = ifid_clear_c;
    assign hz.idex_enable_o  = idex_enable_c;
    assign hz.idex_clear_o   = idex_clear_c;
    assign hz.exmem_enable_o = exmem_enable_c;
    assign hz.memwb_clear_o  = memwb_clear_c;
    assign hz.stall_count_o  = stall_cnt_q;
    assign hz.timeout_o      = timeout_q;
    assign hz.state_o        = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios
// followed by randomized traffic, all checked against a behavioural model.
module tb_pipeline_hazard_controller;

    localparam int unsigned REG_ADDR_W  = 4;
    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 16;
    localparam int          STALL_MAX   = (1 << CNT_W) - 1;

    // Control vector order: {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_clr}
    localparam logic [6:0] C_NONE   = 7'b1101010;
    localparam logic [6:0] C_REDIR  = 7'b1111110;
    localparam logic [6:0] C_LDUSE  = 7'b0001110;
    localparam logic [6:0] C_FROZEN = 7'b0000001;

    logic clk;
    logic rst;

    pipeline_hazard_controller_if #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) hz ();

    pipeline_hazard_controller #(
        .REG_ADDR_W (REG_ADDR_W),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .hz   (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: mode 0 RUN, 1 WAIT, 2 HALT.
    int m_mode;
    int m_waits;
    int m_stall;
    int m_to;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_ctrl();
        return {hz.pc_enable_o, hz.ifid_enable_o, hz.ifid_clear_o, hz.idex_enable_o,
                hz.idex_clear_o, hz.exmem_enable_o, hz.memwb_clear_o};
    endfunction

    task automatic drive(input bit redir, input int rd, input bit mrd, input int rs1,
                         input int rs2, input bit u2, input bit macc, input bit rdy);
        hz.redirect_i       = redir;
        hz.rd_ex_i          = REG_ADDR_W'(rd);
        hz.mem_read_ex_i    = mrd;
        hz.rs1_id_i         = REG_ADDR_W'(rs1);
        hz.rs2_id_i         = REG_ADDR_W'(rs2);
        hz.uses_rs2_id_i    = u2;
        hz.mem_access_mem_i = macc;
        hz.mem_ready_i      = rdy;
    endtask

    task automatic drive_idle();
        drive(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, ".state"}, 32'(hz.state_o), 32'(m_mode));
        check_eq({tag, ".stall"}, 32'(hz.stall_count_o), 32'(m_stall));
        check_eq({tag, ".timeout"}, 32'(hz.timeout_o), 32'(m_to));
    endtask

    // Asynchronous reset asserted between edges; checked before any edge arrives.
    task automatic do_reset(input string tag);
        drive_idle();
        #2 rst = 1'b1;
        #1;
        m_mode = 0; m_waits = 0; m_stall = 0; m_to = 0;
        check_status(tag);
        check_eq({tag, ".ctrl"}, 32'(dut_ctrl()), 32'(C_NONE));
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One cycle with the inputs already driven: check outputs mid-cycle, then advance model.
    task automatic step(input string tag);
        bit         mem_wait, load_use;
        logic [6:0] exp_ctrl;
        int         n_mode, n_waits, n_to;
        mem_wait = hz.mem_access_mem_i && !hz.mem_ready_i;
        load_use = hz.mem_read_ex_i && (hz.rd_ex_i != 0) &&
                   (hz.rd_ex_i == hz.rs1_id_i || (hz.uses_rs2_id_i && hz.rd_ex_i == hz.rs2_id_i));
        n_mode = m_mode; n_waits = m_waits; n_to = m_to;
        if (m_mode == 2) begin
            exp_ctrl = C_FROZEN;
        end else if (mem_wait) begin
            exp_ctrl = C_FROZEN;
            n_waits  = m_waits + 1;
            // Halting on the MEM_TIMEOUT-th consecutive not-ready cycle.
            if (m_mode == 1 && n_waits >= int'(MEM_TIMEOUT)) begin
                n_mode = 2;
                n_to   = 1;
            end else begin
                n_mode = 1;
            end
        end else begin
            n_mode  = 0;
            n_waits = 0;
            if (hz.redirect_i)  exp_ctrl = C_REDIR;
            else if (load_use)  exp_ctrl = C_LDUSE;
            else                exp_ctrl = C_NONE;
        end
        @(negedge clk);
        check_eq({tag, ".ctrl"}, 32'(dut_ctrl()), 32'(exp_ctrl));
        check_status(tag);
        @(posedge clk);
        #1;
        if (!exp_ctrl[6] && m_stall < STALL_MAX) m_stall++;
        m_mode = n_mode; m_waits = n_waits; m_to = n_to;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int burst;
        rst = 1'b1;
        drive_idle();
        m_mode = 0; m_waits = 0; m_stall = 0; m_to = 0;
        #1;
        check_status("por");
        @(posedge clk);
        #1 rst = 1'b0;

        // Load-use on rs1, then the two exclusions.
        drive(1'b0, 3, 1'b1, 3, 0, 1'b0, 1'b0, 1'b1); step("ld_use");
        check_eq("ld_use.cnt1", 32'(hz.stall_count_o), 32'd1);
        drive(1'b0, 0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1); step("ld_x0");
        drive(1'b0, 5, 1'b1, 1, 5, 1'b0, 1'b0, 1'b1); step("ld_nors2");
        drive(1'b0, 5, 1'b1, 1, 5, 1'b1, 1'b0, 1'b1); step("ld_rs2");
        // Redirect overrides a simultaneous load-use.
        drive(1'b1, 3, 1'b1, 3, 3, 1'b1, 1'b0, 1'b1); step("redir_lu");

        // Three wait cycles, then release with redirect.
        do_reset("rst_a");
        repeat (3) begin
            drive(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0); step("mwait");
        end
        drive(1'b1, 2, 1'b1, 2, 0, 1'b0, 1'b1, 1'b1); step("mrel");
        drive_idle(); step("mpost");
        check_eq("mwait.cnt3", 32'(hz.stall_count_o), 32'd3);

        // Timeout after MEM_TIMEOUT not-ready cycles; HALT survives ready.
        do_reset("rst_b");
        repeat (MEM_TIMEOUT) begin
            drive(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0); step("tmo_wait");
        end
        check_eq("tmo.state", 32'(hz.state_o), 32'h2);
        check_eq("tmo.flag", 32'(hz.timeout_o), 32'h1);
        drive(1'b1, 0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1); step("halt_rdy");
        drive_idle(); step("halt_idle");

        // Reset in the middle of a wait.
        do_reset("rst_c");
        repeat (2) begin
            drive(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0); step("pre_rst");
        end
        do_reset("rst_midwait");
        drive_idle(); step("after_rst");

        // Randomized traffic with occasional long memory stalls and resets.
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            bit macc, rdy;
            if (m_mode == 2 && $urandom_range(0, 7) == 0) begin
                do_reset("rnd_rst");
            end
            if (burst > 0) begin
                macc = 1'b1; rdy = 1'b0; burst--;
            end else begin
                macc = ($urandom_range(0, 2) == 0);
                rdy  = ($urandom_range(0, 9) < 6);
                if ($urandom_range(0, 49) == 0) burst = int'($urandom_range(1, 6));
            end
            drive($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  macc, rdy);
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
